// File: rtl/lsu_avalon_host_pkg.sv
// Shared types for the load/store unit: FSM states, completion codes,
// RISC-V funct3 encodings and small decode helpers.
package lsu_avalon_host_pkg;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT_DATA,
    LSU_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_MISALIGNED = 2'b01,
    ST_ILLEGAL    = 2'b10,
    ST_TIMEOUT    = 2'b11
  } lsu_status_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Legality of a request: illegal funct3 wins over misalignment.
  // Stores only have byte/half/word encodings, so 011 is rejected for both.
  function automatic lsu_status_t check_req(input logic       write,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    lsu_status_t s;
    s = ST_OK;
    if (write ? (funct3[2] || funct3 == 3'b011)
              : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) begin
      s = ST_ILLEGAL;
    end else if ((funct3[1:0] == 2'b01 && addr_lo[0]) ||
                 (funct3[1:0] == 2'b10 && addr_lo != 2'b00)) begin
      s = ST_MISALIGNED;
    end
    return s;
  endfunction

  // Lane enables for an access that starts at lane 0.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_avalon_host_if.sv
// Avalon-MM read/write bus between the load/store unit and the data agent.
interface AvalonMmRw;
  import lsu_avalon_host_pkg::*;

  word        address;
  logic       read;
  logic       write;
  logic [3:0] byteenable;
  word        host_to_agent;
  word        agent_to_host;
  logic       waitrequest;
  logic       readdatavalid;

  modport Host (
    output address, read, write, byteenable, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );

  modport Agent (
    input  address, read, write, byteenable, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );

endinterface

// File: rtl/lsu_avalon_host_load_extend.sv
// Sign/zero extension of lane-0-aligned load data according to funct3.
module load_extend
  import lsu_avalon_host_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  word        i_word,
  output word        o_word
);

  // Pick the width from funct3 and extend into a full word.
  always_comb begin
    o_word = i_word;
    case (i_funct3)
      F3_B:    o_word = {{24{i_word[7]}}, i_word[7:0]};
      F3_BU:   o_word = {24'h0, i_word[7:0]};
      F3_H:    o_word = {{16{i_word[15]}}, i_word[15:0]};
      F3_HU:   o_word = {16'h0, i_word[15:0]};
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_avalon_host.sv
// Load/store unit: one outstanding core request at a time, translated to an
// Avalon-MM host transaction, with legality checks and a load timeout.
module lsu_avalon_host
  import lsu_avalon_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  word         req_addr,
  input  word         req_wdata,
  output logic        resp_valid,
  output word         resp_rdata,
  output logic [1:0]  resp_status,
  AvalonMmRw.Host     bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  r_state, w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  word         r_addr;
  word         r_wdata;
  logic [3:0]  r_be;
  word         r_rdata;
  lsu_status_t r_status;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  lsu_status_t w_check;
  word         w_ext;
  logic        w_timeout;

  assign w_accept = req_valid && req_ready;
  assign w_check  = check_req(req_write, req_funct3, req_addr[1:0]);
  // Fires on the last of TIMEOUT_CYCLES cycles spent in WAIT_DATA.
  assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                     ((32'(r_cnt) + 32'd1) == TIMEOUT_CYCLES);

  load_extend u_extend (
    .i_funct3 (r_funct3),
    .i_word   (bus.agent_to_host),
    .o_word   (w_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= LSU_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE:
        if (w_accept) w_next = (w_check == ST_OK) ? LSU_ISSUE : LSU_RESP;
      LSU_ISSUE:
        if (!bus.waitrequest) w_next = r_write ? LSU_RESP : LSU_WAIT_DATA;
      LSU_WAIT_DATA:
        if (bus.readdatavalid || w_timeout) w_next = LSU_RESP;
      LSU_RESP:
        w_next = LSU_IDLE;
      default:
        w_next = LSU_IDLE;
    endcase
  end

  // Core and bus outputs, all derived from registered state.
  always_comb begin
    req_ready          = (r_state == LSU_IDLE) && !rst;
    resp_valid         = (r_state == LSU_RESP);
    resp_rdata         = r_rdata;
    resp_status        = r_status;
    bus.read           = (r_state == LSU_ISSUE) && !r_write;
    bus.write          = (r_state == LSU_ISSUE) && r_write;
    bus.byteenable     = (r_state == LSU_ISSUE) ? r_be : '0;
    bus.address        = r_addr;
    bus.host_to_agent  = r_wdata;
  end

  // Request latch, response data/status capture and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_rdata  <= '0;
      r_status <= ST_OK;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_be     <= byte_enable(req_funct3);
        r_rdata  <= '0;
        r_status <= w_check;
      end
      if (r_state == LSU_WAIT_DATA) begin
        if (bus.readdatavalid) begin
          r_rdata  <= w_ext;
          r_status <= ST_OK;
        end else if (w_timeout) begin
          r_status <= ST_TIMEOUT;
        end
      end
      if (r_state == LSU_ISSUE && !bus.waitrequest && !r_write) begin
        r_cnt <= '0;
      end else if (r_state == LSU_WAIT_DATA && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_avalon_host.sv
// Self-checking bench for lsu_avalon_host: a byte-array Avalon agent with
// programmable waitrequest, plus an independent reference memory model.
module tb_lsu_avalon_host;
  import lsu_avalon_host_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_status;

  AvalonMmRw bus();

  lsu_avalon_host #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_status (resp_status),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- agent ----------------
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  bit          no_data = 0;
  bit          force_rdv = 0;
  bit          rdv_pending = 0;
  logic [31:0] rd_addr = '0;
  int          both_cnt = 0;

  initial begin
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.agent_to_host = '0;
  end

  always @(negedge clk) begin
    if (bus.read && bus.write) both_cnt++;
    bus.readdatavalid = 1'b0;
    if (rdv_pending && !no_data) begin
      bus.readdatavalid = 1'b1;
      for (int i = 0; i < 4; i++) bus.agent_to_host[8*i +: 8] = mem[8'(rd_addr + 32'(i))];
    end else if (force_rdv) begin
      bus.readdatavalid = 1'b1;
      bus.agent_to_host = 32'hAAAA5555;
      force_rdv = 0;
    end
    rdv_pending = 0;
    if (bus.read || bus.write) begin
      if (wcnt == wait_cfg) begin
        bus.waitrequest = 1'b0;
        if (bus.write) begin
          for (int i = 0; i < 4; i++)
            if (bus.byteenable[i]) mem[8'(bus.address + 32'(i))] = bus.host_to_agent[8*i +: 8];
        end else begin
          rdv_pending = 1;
          rd_addr = bus.address;
        end
      end else begin
        bus.waitrequest = 1'b1;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      bus.waitrequest = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_status(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (wr && f3 > 3'd2) return 2'd2;
    if (!wr && (f3 == 3'd3 || f3 > 3'd5)) return 2'd2;
    nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (a % nbytes != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned b0, b1, b2, b3, h;
    b0 = ref_mem[(a + 0) & 255];
    b1 = ref_mem[(a + 1) & 255];
    b2 = ref_mem[(a + 2) & 255];
    b3 = ref_mem[(a + 3) & 255];
    h  = b0 + 256 * b1;
    case (f3)
      3'd0:    return (b0 >= 128) ? b0 + 32'hFFFFFF00 : b0;
      3'd4:    return b0;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return b0 + 256 * b1 + 65536 * b2 + 16777216 * b3;
    endcase
  endfunction

  // ---------------- transaction driver (no checking) ----------------
  // Called at a negedge; that cycle is cycle 0 (accept on the next posedge).
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [1:0] st,
                         output logic [31:0] rd, output int n_rd, output int n_wr,
                         output logic [3:0] be_seen, output logic [31:0] addr_seen,
                         output logic [31:0] wd_seen, output bit unstable);
    bit seen;
    lat = -1; st = '0; rd = '0; n_rd = 0; n_wr = 0;
    be_seen = '0; addr_seen = '0; wd_seen = '0; unstable = 0; seen = 0;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (bus.read)  n_rd++;
      if (bus.write) n_wr++;
      if (bus.read || bus.write) begin
        if (!seen) begin
          seen = 1; be_seen = bus.byteenable; addr_seen = bus.address; wd_seen = bus.host_to_agent;
        end else if (bus.byteenable !== be_seen || bus.address !== addr_seen ||
                     bus.host_to_agent !== wd_seen) begin
          unstable = 1;
        end
      end
      if (resp_valid) begin
        lat = n; st = resp_status; rd = resp_rdata;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during got %b exp 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", req_ready); end
    checks++;
    if ({resp_valid, resp_rdata, resp_status, bus.read, bus.write, bus.byteenable} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b rdata=%h st=%b rd=%b wr=%b be=%b exp all 0",
               resp_valid, resp_rdata, resp_status, bus.read, bus.write, bus.byteenable);
    end
  endtask

  task automatic test_directed_loads;
    logic [2:0]  f3s  [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80, 32'h00007F80, 32'h12347F80};
    logic [3:0]  bes  [5] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1111};
    int lat, n_rd, n_wr; logic [1:0] st; logic [31:0] rd, a_s, w_s; logic [3:0] be_s; bit unst;
    mem[16] = 8'h80; mem[17] = 8'h7F; mem[18] = 8'h34; mem[19] = 8'h12;
    ref_mem[16] = 8'h80; ref_mem[17] = 8'h7F; ref_mem[18] = 8'h34; ref_mem[19] = 8'h12;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      run_req(1'b0, f3s[k], 32'h10, 32'h0, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
      checks++;
      if (rd !== exps[k] || st !== 2'b00) begin
        errors++; $display("FAIL load_ext f3=%b got %h/%b exp %h/00", f3s[k], rd, st, exps[k]);
      end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL load_latency f3=%b got %0d exp 3", f3s[k], lat); end
      checks++;
      if (be_s !== bes[k] || a_s !== 32'h10 || n_rd !== 1 || n_wr !== 0) begin
        errors++; $display("FAIL load_bus f3=%b be=%b addr=%h nrd=%0d nwr=%0d exp be=%b addr=10 nrd=1 nwr=0",
                           f3s[k], be_s, a_s, n_rd, n_wr, bes[k]);
      end
    end
  endtask

  task automatic test_store_then_load;
    int lat, n_rd, n_wr; logic [1:0] st; logic [31:0] rd, a_s, w_s; logic [3:0] be_s; bit unst;
    for (int i = 32; i < 36; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    @(negedge clk);
    run_req(1'b1, F3_H, 32'h20, 32'hDEADBEEF, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
    checks++;
    if (be_s !== 4'b0011 || w_s !== 32'hDEADBEEF || n_wr !== 1 || n_rd !== 0) begin
      errors++; $display("FAIL sh_bus be=%b wdata=%h nwr=%0d nrd=%0d exp be=0011 wdata=deadbeef nwr=1 nrd=0",
                         be_s, w_s, n_wr, n_rd);
    end
    checks++;
    if (lat !== 2 || st !== 2'b00 || rd !== 32'h0) begin
      errors++; $display("FAIL sh_resp lat=%0d st=%b rd=%h exp lat=2 st=00 rd=0", lat, st, rd);
    end
    ref_mem[32] = 8'hEF; ref_mem[33] = 8'hBE;
    @(negedge clk);
    run_req(1'b0, F3_W, 32'h20, 32'h0, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
    checks++;
    if (rd !== ref_load(F3_W, 32'h20) || lat !== 3) begin
      errors++; $display("FAIL lw_after_sh got %h lat=%0d exp %h lat=3", rd, lat, ref_load(F3_W, 32'h20));
    end
  endtask

  task automatic test_faults;
    logic        wrs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [6] = '{3'b010, 3'b100, 3'b011, 3'b101, 3'b001, 3'b010};
    logic [31:0] as  [6] = '{32'h13, 32'h10, 32'h10, 32'h11, 32'h11, 32'h22};
    logic [1:0]  sts [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    int lat, n_rd, n_wr; logic [1:0] st; logic [31:0] rd, a_s, w_s; logic [3:0] be_s; bit unst;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      run_req(wrs[k], f3s[k], as[k], 32'hFFFFFFFF, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
      checks++;
      if (st !== sts[k] || lat !== 1 || rd !== 32'h0 || n_rd + n_wr !== 0) begin
        errors++; $display("FAIL fault_%0d st=%b lat=%0d rd=%h bus=%0d exp st=%b lat=1 rd=0 bus=0",
                           k, st, lat, rd, n_rd + n_wr, sts[k]);
      end
    end
  endtask

  task automatic test_waitrequest;
    int lat, n_rd, n_wr; logic [1:0] st; logic [31:0] rd, a_s, w_s; logic [3:0] be_s; bit unst;
    @(negedge clk);
    wait_cfg = 3;
    run_req(1'b0, F3_W, 32'h10, 32'h0, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
    wait_cfg = 0;
    checks++;
    if (lat !== 6 || n_rd !== 4) begin
      errors++; $display("FAIL wait_latency lat=%0d read_cycles=%0d exp 6/4", lat, n_rd);
    end
    checks++;
    if (unst !== 1'b0 || be_s !== 4'b1111 || a_s !== 32'h10) begin
      errors++; $display("FAIL wait_stable unstable=%b be=%b addr=%h exp 0/1111/10", unst, be_s, a_s);
    end
    checks++;
    if (rd !== ref_load(F3_W, 32'h10) || st !== 2'b00) begin
      errors++; $display("FAIL wait_data got %h/%b exp %h/00", rd, st, ref_load(F3_W, 32'h10));
    end
  endtask

  task automatic test_back_to_back_random;
    int lat, n_rd, n_wr, exp_lat, nbytes; logic [1:0] st, exp_st; logic [31:0] rd, a_s, w_s, exp_rd;
    logic [3:0] be_s; bit unst; logic wr; logic [2:0] f3; logic [31:0] addr, wd; int unsigned w;
    for (int i = 64; i < 132; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    for (int it = 0; it < 80; it++) begin
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      if (wr && f3 == 3'd3) f3 = 3'd2;
      addr = ($urandom() & 32'hFFFFFF3F) | 32'h40;
      wd   = $urandom();
      w    = $urandom_range(0, 2);
      exp_st  = ref_status(wr, f3, addr);
      exp_lat = (exp_st != 0) ? 1 : (wr ? 2 : 3) + int'(w);
      exp_rd  = (exp_st == 0 && !wr) ? ref_load(f3, addr) : 32'h0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_ready it=%0d ready=%b valid=%b exp 1/0", it, req_ready, resp_valid);
      end
      wait_cfg = w;
      run_req(wr, f3, addr, wd, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
      wait_cfg = 0;
      checks++;
      if (st !== exp_st || rd !== exp_rd || lat !== exp_lat) begin
        errors++; $display("FAIL rand it=%0d wr=%b f3=%b a=%h got st=%b rd=%h lat=%0d exp st=%b rd=%h lat=%0d",
                           it, wr, f3, addr, st, rd, lat, exp_st, exp_rd, exp_lat);
      end
      checks++;
      if (unst || (n_rd + n_wr > 0 && a_s !== addr)) begin
        errors++; $display("FAIL rand_bus it=%0d unstable=%b addr=%h exp stable addr=%h", it, unst, a_s, addr);
      end
      if (wr && exp_st == 0) begin
        nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int b = 0; b < nbytes; b++) ref_mem[(addr + b) & 255] = 8'((wd >> (8 * b)) & 255);
      end
    end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL read_write_overlap got %0d exp 0", both_cnt); end
  endtask

  task automatic test_timeout;
    int lat, n_rd, n_wr; logic [1:0] st; logic [31:0] rd, a_s, w_s; logic [3:0] be_s; bit unst;
    bit bad;
    @(negedge clk);
    no_data = 1;
    run_req(1'b0, F3_W, 32'h10, 32'h0, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
    no_data = 0;
    checks++;
    if (st !== 2'b11 || lat !== 10 || rd !== 32'h0) begin
      errors++; $display("FAIL timeout st=%b lat=%0d rd=%h exp 11/10/0", st, lat, rd);
    end
    @(negedge clk);
    force_rdv = 1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL late_rdv got reaction=1 exp 0"); end
    run_req(1'b0, F3_BU, 32'h12, 32'h0, lat, st, rd, n_rd, n_wr, be_s, a_s, w_s, unst);
    checks++;
    if (rd !== ref_load(F3_BU, 32'h12) || st !== 2'b00 || lat !== 3) begin
      errors++; $display("FAIL post_timeout got %h/%b/%0d exp %h/00/3", rd, st, lat, ref_load(F3_BU, 32'h12));
    end
  endtask

  task automatic test_reset_in_wait;
    bit bad;
    @(negedge clk);
    no_data = 1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || {resp_valid, resp_rdata, resp_status, bus.read, bus.write, bus.byteenable} !== '0) begin
      errors++; $display("FAIL reset_wait ready=%b valid=%b rdata=%h st=%b rd=%b wr=%b be=%b exp 1 then all 0",
                         req_ready, resp_valid, resp_rdata, resp_status, bus.read, bus.write, bus.byteenable);
    end
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad = 1;
    end
    no_data = 0;
    checks++;
    if (bad) begin errors++; $display("FAIL reset_wait_no_resp got resp_valid=1 exp 0"); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_directed_loads();
    test_store_then_load();
    test_faults();
    test_waitrequest();
    test_back_to_back_random();
    test_timeout();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired exp finish before 500000");
    $fatal(1);
  end

endmodule
